csr_timer: RTL and testbench
============================

# csr_timer

Constant-timer block for the LoongArch32 CSR file: holds CSR.TCFG, produces CSR.TVAL, and raises the timer interrupt (ESTAT.IS[11]) that the exception unit samples. It is the write/countdown counterpart to the free-running stable counter that the rdcnt instructions read. It sits beside the CSR register file in the execute stage. TCFG/TICLR writes arrive from the csrwr/csrxchg path, and TCFG/TVAL read data goes back to the CSR read mux.

## Interface
- TIMER_WIDTH, 32, n = width of TVAL and the TCFG InitVal span, legal range 8..32.
- clk  in  1  core clock.
- rst_n  in  1  reset, asynchronous, active-low.
- tcfg_we  in  1  write strobe for CSR.TCFG; masking is already applied upstream.
- tcfg_wdata  in  32  new TCFG value.
- ticlr_we  in  1  write strobe for CSR.TICLR.
- ticlr_wdata  in  32  TICLR write data; only bit0 (CLR) is meaningful.
- tcfg  out  32  current TCFG, with bits [31:TIMER_WIDTH] read as 0.
- tval  out  32  current countdown value, zero-extended from TIMER_WIDTH.
- timer_int  out  1  timer interrupt pending (TI), level.

## Operation
- TCFG fields:
  - bit0 En.
  - bit1 Periodic.
  - [n-1:2] InitVal.
- Reload value R = {InitVal, 2'b00}.
- Internal state:
  - tcfg_q.
  - tval_q (n bits).
  - armed (1: counter is decrementing).
  - ti_q.
- TCFG write:
  - tcfg_q <= wdata.
  - tval_q <= R of the new value.
  - armed <= new En.
- Countdown runs each cycle with armed=1 and no TCFG write:
  - tval_q != 0: tval_q <= tval_q - 1.
  - tval_q == 0 (expiry): ti_q <= 1.
    - Periodic=1: tval_q <= R, armed stays 1.
    - Periodic=0: tval_q <= all-ones (n bits), armed <= 0 (one-shot halt).
- armed=0: tval_q holds its value, and no expiry occurs.
- En cleared by a TCFG write stops counting after the reload. There is no expiry from the old value in that cycle.
- TICLR write with wdata[0]=1 clears ti_q. A TICLR write with wdata[0]=0 has no effect.
- TICLR never changes tval_q or armed.
- Simultaneous events:
  - Expiry and TICLR clear in the same cycle: ti_q ends at 1. Set wins, so a new tick is never lost.
  - Expiry (old tval_q==0, armed) and TCFG write in the same cycle: ti_q <= 1, and tval_q/armed come from the write.
  - TCFG write and TICLR in the same cycle: both take effect independently.
- Arithmetic is n-bit unsigned. tval_q never underflows: the 0 case is handled by reload or halt.
- InitVal=0 with Periodic=1: R=0, so the timer expires on every armed cycle and timer_int stays set.
- Reset values:
  - tcfg = 0.
  - tval = 0.
  - timer_int = 0.
  - armed = 0.

## Timing
- All outputs are registered. They reflect state after the clock edge.
- TCFG write at edge t: at t+1, tcfg = new value and tval = R.
  - If En=1, tval decrements from the t+2 edge onward.
- Expiry: tval==0 is visible at cycle k; timer_int rises at k+1, together with reload or halt.
- Periodic interval: R+1 cycles between consecutive timer_int set events.
- First expiry after a write at t is at t+1+R; timer_int rises at t+2+R.
- TICLR at edge t: timer_int is low at t+1, unless an expiry also happens at edge t.
- An asynchronous rst_n assertion mid-count forces all state to the reset values immediately. Counting resumes only after a new TCFG write.

## Test plan
- Reset, then idle 20 cycles -> tcfg=0, tval=0, timer_int=0 throughout.
- TCFG write 0x0000_0007 (En=1, Periodic=1, InitVal=1) at t:
  - tval = 4, 3, 2, 1, 0 at t+1..t+5.
  - timer_int=1 and tval=4 at t+6.
  - Next set event lands 5 cycles later.
- One-shot: TCFG write 0x0000_0009 (En=1, Periodic=0, InitVal=2) -> tval counts 8..0, then 0xFFFF_FFFF held; timer_int=1 and stays high; no further decrement.
- TICLR wdata=1 while timer_int=1 and no expiry -> timer_int=0 next cycle. TICLR wdata=0 -> timer_int unchanged. Also issue TICLR on the exact expiry cycle -> timer_int stays 1.
- Mid-count TCFG write 0x0000_0040 (En=0) while tval=5 -> tval=0x40 next cycle and held; timer_int is not set. Also write the TCFG on the tval==0 expiry cycle -> timer_int=1, tval = new R.
- Assert rst_n low mid-count (tval=3, timer_int=1) -> all outputs 0 immediately. After release, tval stays 0 until the next TCFG write.

Source files
------------

// File: rtl/csr_timer_if.sv
// CSR-side port bundle of the constant timer: TCFG/TICLR write strobes and
// data from the csrwr/csrxchg path, plus TCFG/TVAL/TI back to the CSR read mux.
interface csr_timer_if;

  // Write path from the CSR write logic (masking already applied upstream).
  logic        tcfg_we;
  logic [31:0] tcfg_wdata;
  logic        ticlr_we;
  logic [31:0] ticlr_wdata;

  // Read path to the CSR read mux and the exception unit.
  logic [31:0] tcfg;
  logic [31:0] tval;
  logic        timer_int;

  // CSR write logic side.
  modport master (
    output tcfg_we,
    output tcfg_wdata,
    output ticlr_we,
    output ticlr_wdata,
    input  tcfg,
    input  tval,
    input  timer_int
  );

  // Timer side.
  modport slave (
    input  tcfg_we,
    input  tcfg_wdata,
    input  ticlr_we,
    input  ticlr_wdata,
    output tcfg,
    output tval,
    output timer_int
  );

endinterface

// File: rtl/csr_timer.sv
// LoongArch32 constant timer: holds CSR.TCFG, counts CSR.TVAL down and raises
// the level timer interrupt TI (ESTAT.IS[11]). TICLR.CLR clears TI.
//
// TCFG layout (TIMER_WIDTH = n, legal range 8..32):
//   bit 0      En        start counting after the write
//   bit 1      Periodic  reload on expiry instead of halting
//   [n-1:2]    InitVal   reload value is {InitVal, 2'b00}
module csr_timer #(
  parameter int unsigned TIMER_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  csr_timer_if.slave  bus
);

  localparam int unsigned W = TIMER_WIDTH;

  typedef logic [W-1:0] cnt_t;

  // Counter run state: RUN decrements every cycle, HALT holds TVAL.
  typedef enum logic {
    ST_HALT = 1'b0,
    ST_RUN  = 1'b1
  } run_e;

  // Reload value derived from a TCFG image: InitVal with two zero LSBs.
  function automatic cnt_t reload_of(input cnt_t cfg);
    return {cfg[W-1:2], 2'b00};
  endfunction

  cnt_t tcfg_q;
  cnt_t tval_q;
  run_e run_q;
  logic ti_q;

  cnt_t new_cfg;
  logic at_zero;
  logic expire;
  logic ti_clear;

  // Only the low n bits of TCFG exist; the rest read as zero. Only
  // TICLR.CLR carries meaning. The leftover bits feed this reduction so
  // they are visibly consumed.
  logic unused_wdata_bits;
  assign unused_wdata_bits = ^{bus.ticlr_wdata[31:1], bus.tcfg_wdata};

  // Decode the write/clear requests and the expiry condition.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    new_cfg  = bus.tcfg_wdata[W-1:0];
    at_zero  = (tval_q == '0);
    // Expiry depends only on the old counter state; a TCFG write in the
    // same cycle still raises TI but takes over TVAL and the run state.
    expire   = (run_q == ST_RUN) && at_zero;
    ti_clear = bus.ticlr_we && bus.ticlr_wdata[0];
  end

  // TCFG image, countdown value and run state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcfg_q <= '0;
      tval_q <= '0;
      run_q  <= ST_HALT;
    end else if (bus.tcfg_we) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      tcfg_q <= new_cfg;
      tval_q <= reload_of(new_cfg);
      run_q  <= new_cfg[0] ? ST_RUN : ST_HALT;
    end else if (run_q == ST_RUN) begin
      if (at_zero) begin
        if (tcfg_q[1]) begin
          // Periodic: restart from the reload value, keep running.
          tval_q <= reload_of(tcfg_q);
        end else begin
          // One-shot: park at all-ones and stop.
          tval_q <= '1;
          run_q  <= ST_HALT;
        end
      end else begin
        tval_q <= tval_q - cnt_t'(1);
      end
    end
  end

  // Interrupt pending flag: set on expiry, cleared by TICLR.CLR; set wins
  // so a tick landing on the clear cycle is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ti_q <= 1'b0;
    end else if (expire) begin
      ti_q <= 1'b1;
    end else if (ti_clear) begin
      ti_q <= 1'b0;
    end
  end

  // Registered state straight to the read mux, zero-extended to 32 bits.
  assign bus.tcfg      = 32'(tcfg_q);
  assign bus.tval      = 32'(tval_q);
  assign bus.timer_int = ti_q;

endmodule

// File: tb/tb_csr_timer.sv
// Directed bench for csr_timer: reset/idle, periodic countdown and reload,
// one-shot halt, TICLR clear behaviour, mid-count reconfiguration,
// write-on-expiry and asynchronous reset mid-count.
module tb_csr_timer;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_errors;

  csr_timer_if bus ();

  csr_timer #(
    .TIMER_WIDTH(32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t",
               tag, actual, expected, $time);
    end
  endtask

  // Check all three outputs at once.
  task automatic expect_state(input string tag, input logic [31:0] cfg,
                              input logic [31:0] val, input logic ti);
    check({tag, ".tcfg"}, bus.tcfg, cfg);
    check({tag, ".tval"}, bus.tval, val);
    check({tag, ".ti"}, {31'd0, bus.timer_int}, {31'd0, ti});
  endtask

  // Advance one clock edge, sample 1 time unit later, drop the strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.tcfg_we  = 1'b0;
    bus.ticlr_we = 1'b0;
  endtask

  task automatic set_tcfg(input logic [31:0] v);
    bus.tcfg_we    = 1'b1;
    bus.tcfg_wdata = v;
  endtask

  task automatic set_ticlr(input logic [31:0] v);
    bus.ticlr_we    = 1'b1;
    bus.ticlr_wdata = v;
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    rst_n           = 1'b0;
    bus.tcfg_we     = 1'b0;
    bus.tcfg_wdata  = '0;
    bus.ticlr_we    = 1'b0;
    bus.ticlr_wdata = '0;

    // Reset and idle.
    #3;
    expect_state("rst", 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      expect_state("idle", 32'h0, 32'h0, 1'b0);
    end

    // Periodic, InitVal=1 -> R=4.
    set_tcfg(32'h0000_0007);
    tick();
    expect_state("per_load", 32'h7, 32'd4, 1'b0);
    for (int v = 3; v >= 0; v--) begin
      tick();
      expect_state("per_cnt", 32'h7, v, 1'b0);
    end
    tick();
    expect_state("per_exp", 32'h7, 32'd4, 1'b1);

    // Clear with no expiry pending, then the next set event 5 edges after the first.
    set_ticlr(32'h1);
    tick();
    expect_state("clr1", 32'h7, 32'd3, 1'b0);
    for (int v = 2; v >= 0; v--) begin
      tick();
      expect_state("per_cnt2", 32'h7, v, 1'b0);
    end
    tick();
    expect_state("per_exp2", 32'h7, 32'd4, 1'b1);

    // TICLR with CLR=0 does nothing.
    set_ticlr(32'hFFFF_FFFE);
    tick();
    expect_state("clr0", 32'h7, 32'd3, 1'b1);
    for (int v = 2; v >= 0; v--) begin
      tick();
      expect_state("per_cnt3", 32'h7, v, 1'b1);
    end
    // TICLR on the expiry cycle: set wins.
    set_ticlr(32'h1);
    tick();
    expect_state("clr_on_exp", 32'h7, 32'd4, 1'b1);

    // One-shot, InitVal=2 -> R=8; TICLR in the same cycle as the TCFG write.
    set_ticlr(32'h1);
    set_tcfg(32'h0000_0009);
    tick();
    expect_state("os_load", 32'h9, 32'd8, 1'b0);
    for (int v = 7; v >= 0; v--) begin
      tick();
      expect_state("os_cnt", 32'h9, v, 1'b0);
    end
    tick();
    expect_state("os_exp", 32'h9, 32'hFFFF_FFFF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_state("os_hold", 32'h9, 32'hFFFF_FFFF, 1'b1);
    end

    // Mid-count write with En=0 at tval=5.
    set_ticlr(32'h1);
    set_tcfg(32'h0000_0009);
    tick();
    expect_state("mid_load", 32'h9, 32'd8, 1'b0);
    for (int v = 7; v >= 5; v--) begin
      tick();
      expect_state("mid_cnt", 32'h9, v, 1'b0);
    end
    set_tcfg(32'h0000_0040);
    tick();
    expect_state("mid_stop", 32'h40, 32'h40, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_state("mid_hold", 32'h40, 32'h40, 1'b0);
    end

    // TCFG write on the expiry cycle: TI set, TVAL/run state from the write.
    set_tcfg(32'h0000_0007);
    tick();
    expect_state("wexp_load", 32'h7, 32'd4, 1'b0);
    for (int v = 3; v >= 0; v--) begin
      tick();
      expect_state("wexp_cnt", 32'h7, v, 1'b0);
    end
    set_tcfg(32'h0000_000D);
    tick();
    expect_state("wexp", 32'hD, 32'd12, 1'b1);
    tick();
    expect_state("wexp_run", 32'hD, 32'd11, 1'b1);

    // Asynchronous reset mid-count with tval=3, TI=1.
    set_tcfg(32'h0000_0007);
    tick();
    expect_state("ar_load", 32'h7, 32'd4, 1'b1);
    tick();
    expect_state("ar_cnt", 32'h7, 32'd3, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    expect_state("async_rst", 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_state("post_rst", 32'h0, 32'h0, 1'b0);
    end
    set_tcfg(32'h0000_0007);
    tick();
    expect_state("post_rst_load", 32'h7, 32'd4, 1'b0);
    tick();
    expect_state("post_rst_cnt", 32'h7, 32'd3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
